// File: rtl/pattern_serializer.sv
`default_nettype none
// ==========================================================================
// pattern_serializer - MSB-first pattern transmitter with golden 01[0*]1 counter
// Optional macro: SERIALIZER_REPEAT_EN adds repeat_en (continuous replay). Rev 1.0
// ==========================================================================
module pattern_serializer #(
    parameter int WIDTH = 24,
    parameter int LEN_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             load,
`ifdef SERIALIZER_REPEAT_EN
    input  logic             repeat_en,
`endif
    input  logic [WIDTH-1:0] pattern_in,
    input  logic [LEN_W-1:0] length_in,
    output logic             sig_out,
    output logic             busy,
    output logic             done,
    output logic [6:0]       exp_count,
    output logic [6:0]       disp0,
    output logic [6:0]       disp1
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        DET_S0 = 2'd0,
        DET_S1 = 2'd1,
        DET_S2 = 2'd2
    } det_t;

    localparam logic [LEN_W:0] MAX_LEN = (LEN_W+1)'(WIDTH);
    localparam logic [6:0]     SEG_ZERO = 7'b1000000;

    state_t           state;
    det_t             det;
    logic [WIDTH-1:0] shift_q;
    logic [LEN_W-1:0] remain;
    logic [3:0]       ones;
    logic [3:0]       tens;
`ifdef SERIALIZER_REPEAT_EN
    logic [WIDTH-1:0] pat_q;
    logic [LEN_W-1:0] len_q;
`endif

    logic       len_ok;
    logic       retire;
    logic       hit;
    logic       last_bit;
    logic [6:0] count_nxt;
    logic [3:0] ones_nxt;
    logic [3:0] tens_nxt;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    // The bit on sig_out retires at an enabled edge in SEND; the detector eats it then.
    always_comb begin
        len_ok    = (length_in != '0) && ({1'b0, length_in} <= MAX_LEN);
        retire    = (state == SEND) && ena;
        hit       = retire && (det == DET_S2) && sig_out;
        last_bit  = (remain == LEN_W'(1));
        count_nxt = exp_count;
        ones_nxt  = ones;
        tens_nxt  = tens;
        if (hit && (exp_count != 7'd99)) begin
            count_nxt = exp_count + 7'd1;
            if (ones == 4'd9) begin
                ones_nxt = 4'd0;
                tens_nxt = tens + 4'd1;
            end else begin
                ones_nxt = ones + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            det       <= DET_S0;
            shift_q   <= '0;
            remain    <= '0;
            sig_out   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            exp_count <= 7'd0;
            ones      <= 4'd0;
            tens      <= 4'd0;
            disp0     <= SEG_ZERO;
            disp1     <= SEG_ZERO;
`ifdef SERIALIZER_REPEAT_EN
            pat_q     <= '0;
            len_q     <= '0;
`endif
        end else begin
            exp_count <= count_nxt;
            ones      <= ones_nxt;
            tens      <= tens_nxt;
            disp0     <= seg7(ones_nxt);
            disp1     <= seg7(tens_nxt);

            if (retire) begin
                case (det)
                    DET_S0:  if (!sig_out) det <= DET_S1;
                    DET_S1:  if (sig_out)  det <= DET_S2;
                    DET_S2:  if (sig_out)  det <= DET_S0;
                    default: det <= DET_S0;
                endcase
            end

            case (state)
                IDLE: begin
                    sig_out <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    if (load && len_ok) begin
                        state   <= SEND;
                        busy    <= 1'b1;
                        shift_q <= pattern_in;
                        remain  <= length_in;
                        sig_out <= pattern_in[WIDTH-1];
                        det     <= DET_S0;
`ifdef SERIALIZER_REPEAT_EN
                        pat_q   <= pattern_in;
                        len_q   <= length_in;
`endif
                    end
                end
                SEND: begin
                    if (ena) begin
                        if (last_bit) begin
`ifdef SERIALIZER_REPEAT_EN
                            // Replay without a gap; detector state carries over.
                            if (repeat_en) begin
                                shift_q <= pat_q;
                                remain  <= len_q;
                                sig_out <= pat_q[WIDTH-1];
                            end else
`endif
                            begin
                                state   <= DONE;
                                busy    <= 1'b0;
                                done    <= 1'b1;
                                sig_out <= 1'b0;
                            end
                        end else begin
                            shift_q <= shift_q << 1;
                            sig_out <= shift_q[WIDTH-2];
                            remain  <= remain - LEN_W'(1);
                        end
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    sig_out <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    sig_out <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pattern_serializer.sv
`default_nettype none
// ==========================================================================
// tb_pattern_serializer - scoreboard bench for pattern_serializer. Rev 1.0
// ==========================================================================
module tb_pattern_serializer;

    localparam int WIDTH = 24;
    localparam int LEN_W = 5;
    localparam logic [23:0] P35 = 24'b000100110001011101010011;

    logic             clk = 1'b0;
    logic             rst;
    logic             ena;
    logic             load;
    logic [WIDTH-1:0] pattern_in;
    logic [LEN_W-1:0] length_in;
    logic             sig_out;
    logic             busy;
    logic             done;
    logic [6:0]       exp_count;
    logic [6:0]       disp0;
    logic [6:0]       disp1;
`ifdef SERIALIZER_REPEAT_EN
    logic             repeat_en = 1'b0;
`endif

    int total = 0;
    int bad   = 0;
    int model_cnt = 0;
    bit bitq[$];
    int doneq[$];
    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000};

    always #5 clk = ~clk;

    pattern_serializer #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .load       (load),
`ifdef SERIALIZER_REPEAT_EN
        .repeat_en  (repeat_en),
`endif
        .pattern_in (pattern_in),
        .length_in  (length_in),
        .sig_out    (sig_out),
        .busy       (busy),
        .done       (done),
        .exp_count  (exp_count),
        .disp0      (disp0),
        .disp1      (disp1)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: every presented bit is compared; popped when the coming edge retires it.
    always @(negedge clk) begin
        int e;
        if (rst === 1'b0) begin
            if (busy === 1'b1) begin
                if (bitq.size() == 0) begin
                    check("unexpected_bit", 32'd1, 32'd0);
                end else begin
                    check("sig_out", sig_out, bitq[0]);
                    if (ena) void'(bitq.pop_front());
                end
            end
            if (done === 1'b1) begin
                check("done_busy", busy, 0);
                check("done_sig_out", sig_out, 0);
                check("bits_left", bitq.size(), 0);
                if (doneq.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = doneq.pop_front();
                    check("exp_count", exp_count, e);
                    check("disp0", disp0, seg_tab[e % 10]);
                    check("disp1", disp1, seg_tab[e / 10]);
                end
            end
        end
    end

    task automatic rst_pulse();
        rst = 1'b1;
        load = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_cnt = 0;
        bitq.delete();
        doneq.delete();
    endtask

    // Issue one load, queue the expected stream and count, run until done.
    task automatic send(input logic [23:0] pat, input int len, input bit toggle, input int junk_at);
        int st;
        int inc;
        int cyc;
        bit seen;
        bit b;
        st  = 0;
        inc = 0;
        for (int i = 0; i < len; i++) begin
            b = pat[23-i];
            bitq.push_back(b);
            case (st)
                0: if (!b) st = 1;
                1: if (b) st = 2;
                default: if (b) begin st = 0; inc++; end
            endcase
        end
        model_cnt = (model_cnt + inc > 99) ? 99 : model_cnt + inc;
        doneq.push_back(model_cnt);
        load = 1'b1;
        pattern_in = pat;
        length_in = len[4:0];
        ena = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
        pattern_in = 24'hA5A5A5;
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 200) begin
            if (toggle) ena = ~ena;
            if (cyc == junk_at) begin
                load = 1'b1;
                pattern_in = ~pat;
                length_in = 5'd7;
            end
            @(posedge clk); #1;
            load = 1'b0;
            cyc++;
            if (done === 1'b1) seen = 1'b1;
        end
        check("done_cycles", cyc, toggle ? 2 * len : len);
        ena = 1'b0;
        @(posedge clk); #1;
        ena = 1'b1;
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);
        check("idle_sig_out", sig_out, 0);
    endtask

    initial begin
        bit any_done;
        rst = 1'b1;
        ena = 1'b1;
        load = 1'b1;
        pattern_in = 24'hFFFFFF;
        length_in = 5'd8;
        repeat (3) @(posedge clk);
        #1;
        check("rst_sig_out", sig_out, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_exp_count", exp_count, 0);
        check("rst_disp0", disp0, 7'b1000000);
        check("rst_disp1", disp1, 7'b1000000);
        rst = 1'b0;
        load = 1'b0;
        @(posedge clk); #1;

        // Reference pattern, continuous enable
        send(P35, 24, 1'b0, -1);
        check("p35_count", exp_count, 4);
        check("p35_disp0", disp0, 7'b0011001);
        check("p35_disp1", disp1, 7'b1000000);

        // Same pattern, enable toggling
        rst_pulse();
        send(P35, 24, 1'b1, -1);
        check("p35t_count", exp_count, 4);

        // Short patterns, left-aligned because bit WIDTH-1 goes first
        rst_pulse();
        send(24'h600000, 3, 1'b0, -1);
        check("p011_count", exp_count, 1);
        send(24'hC00000, 2, 1'b0, -1);
        check("p11_count", exp_count, 1);
        send(24'h800000, 1, 1'b0, -1);
        check("p1_count", exp_count, 1);

        // Abort at bit 10
        rst_pulse();
        for (int i = 0; i < 24; i++) bitq.push_back(P35[23-i]);
        load = 1'b1;
        pattern_in = P35;
        length_in = 5'd24;
        @(posedge clk); #1;
        load = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("pre_abort_busy", busy, 1);
        check("pre_abort_count", exp_count, 1);
        rst = 1'b1;
        bitq.delete();
        @(posedge clk); #1;
        check("abort_busy", busy, 0);
        check("abort_sig_out", sig_out, 0);
        check("abort_done", done, 0);
        check("abort_count", exp_count, 0);
        rst = 1'b0;
        model_cnt = 0;
        any_done = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) any_done = 1'b1;
        end
        check("abort_quiet", any_done, 0);

        // Illegal lengths, then a load during SEND
        load = 1'b1;
        pattern_in = 24'hFFFFFF;
        length_in = 5'd0;
        @(posedge clk); #1;
        check("len0_ignored", busy, 0);
        length_in = 5'd25;
        @(posedge clk); #1;
        check("len25_ignored", busy, 0);
        load = 1'b0;
        @(posedge clk); #1;
        send(P35, 24, 1'b0, 5);
        check("junk_count", exp_count, 4);

        // Saturation: 0101... yields 6 detections per load
        rst_pulse();
        for (int k = 0; k < 17; k++) send(24'h555555, 24, 1'b0, -1);
        check("sat_count", exp_count, 99);
        check("sat_disp0", disp0, 7'b0010000);
        check("sat_disp1", disp1, 7'b0010000);

        check("queues_empty", bitq.size() + doneq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
